reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
- Top-level sequencer for the reaction-timer game. It sits between the debounced button pulses and the 7-segment display path.
- Generates a pseudo-random wait, lights the stimulus LED, then measures reaction time in milliseconds from an internal ms prescaler.
- Flags early presses (cheat) and timeouts, and presents a held result for the display mux.

Parameters:
- CLK_PER_MS, 100000, clock cycles per millisecond tick (100 MHz clock).
- MIN_DELAY_MS, 2000, minimum random wait in ms.
- DELAY_MASK, 8191, mask applied to the LFSR for the random wait extension (wait = MIN_DELAY_MS + (lfsr & DELAY_MASK)).
- TIMEOUT_MS, 1000, reaction window in ms; reaching it ends the measurement.
- EARLY_CODE, 9999, value reported on reaction_ms_o for a cheat.

Ports:
- clk_i  input  1  system clock.
- reset_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle pulse: begin a round.
- stop_i  input  1  one-cycle pulse: player response.
- clear_i  input  1  one-cycle pulse: abort/return to idle.
- led_o  output  1  stimulus LED.
- reaction_ms_o  output  14  measured or coded result.
- result_valid_o  output  1  high while in RESULT.
- early_o  output  1  cheat flag (valid with result_valid_o).
- timeout_o  output  1  timeout flag (valid with result_valid_o).
- state_o  output  2  IDLE=0, WAIT=1, MEASURE=2, RESULT=3 (display mux select).
- best_ms_o  output  14  best valid time (see Optional Feature).

Behaviour:
- Single clock domain (clk_i); reset_ni asynchronous, active-low. All flops clear asynchronously on reset_ni=0.
- Reset values:
  - state = IDLE.
  - led_o, result_valid_o, early_o, timeout_o = 0.
  - reaction_ms_o = 0; best_ms_o = 0.
  - LFSR = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every clock in every state (player timing provides entropy).
- ms prescaler: 0..CLK_PER_MS-1. ms_tick asserts the cycle the prescaler equals CLK_PER_MS-1. Prescaler clears on every state entry.
- Input priority: clear_i > stop_i > start_i. Any state with clear_i=1 goes to IDLE next cycle and clears all result outputs and flags.
- IDLE:
  - start_i latches delay_ms = MIN_DELAY_MS + (lfsr & DELAY_MASK) and clears the ms counter. Next state WAIT.
  - stop_i is ignored.
- WAIT:
  - ms counter increments on ms_tick.
  - stop_i: next state RESULT with early_o=1, reaction_ms_o=EARLY_CODE, led_o stays 0.
  - When ms counter == delay_ms (checked after stop_i): next state MEASURE, ms counter cleared to 0, led_o=1 from the first MEASURE cycle.
  - start_i is ignored.
- MEASURE:
  - ms counter increments on ms_tick.
  - stop_i in cycle N: RESULT at edge N+1, reaction_ms_o = ms counter value in cycle N (not incremented), led_o=0.
  - Else if ms counter == TIMEOUT_MS: RESULT, timeout_o=1, reaction_ms_o=TIMEOUT_MS, led_o=0.
  - stop_i and timeout in the same cycle: stop wins, timeout_o=0, reported value = TIMEOUT_MS.
  - start_i is ignored.
- RESULT:
  - result_valid_o=1; reaction_ms_o, early_o and timeout_o are held.
  - start_i and stop_i are ignored; only clear_i exits.
- Widths: ms counter is 14 bits and saturates at 16383 (unreachable with defaults). delay_ms is 14 bits. Parameter values above 16383 are illegal.
- Latency: every transition takes one clock from the qualifying input or counter condition. Outputs are registered.
- state_o encodes the registered state.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Defined:
  - On entry to RESULT with early_o=0 and timeout_o=0, best_ms_o updates to min(best_ms_o, reaction_ms_o). A stored value of 0 means "none", so the first valid result always loads.
  - clear_i does not reset best_ms_o; only reset_ni does.
- Undefined: best_ms_o is tied to 0 and no comparator or register is synthesized.

Test Plan (CLK_PER_MS=4, MIN_DELAY_MS=2, DELAY_MASK=3, TIMEOUT_MS=10):
- Reset release, then start_i with lfsr&3=1 -> WAIT; led_o rises exactly 3 ms (12 clocks + 1) after start; state_o=2.
- In MEASURE, stop_i after 5 ms ticks -> next cycle state_o=3, result_valid_o=1, reaction_ms_o=5, led_o=0, early_o=0.
- stop_i during WAIT -> RESULT, early_o=1, reaction_ms_o=9999, led_o never asserted.
- No stop_i in MEASURE -> after 10 ms ticks, RESULT, timeout_o=1, reaction_ms_o=10. Then stop_i coincident with counter==10 -> timeout_o=0, reaction_ms_o=10.
- clear_i in each of WAIT/MEASURE/RESULT, and reset_ni low mid-MEASURE -> IDLE next cycle (reset: immediately), all flags 0, led_o 0. start_i in RESULT -> no change.
- REACTION_BEST_TIME_EN defined: valid results 7, then 4, then 6, then early -> best_ms_o = 7, 4, 4, 4. Undefined: best_ms_o constant 0.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: reaction-timer game sequencer (random wait, measure, result).
// Define REACTION_BEST_TIME_EN to keep the best valid reaction time on best_ms_o.
module reaction_timer_ctrl #(
  parameter int CLK_PER_MS   = 100000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int DELAY_MASK   = 8191,
  parameter int TIMEOUT_MS   = 1000,
  parameter int EARLY_CODE   = 9999
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  output logic        led_o,
  output logic [13:0] reaction_ms_o,
  output logic        result_valid_o,
  output logic        early_o,
  output logic        timeout_o,
  output logic [1:0]  state_o,
  output logic [13:0] best_ms_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    MEASURE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [13:0] MS_MAX = 14'h3fff;
  localparam logic [13:0] TMO = 14'(TIMEOUT_MS);
  localparam logic [13:0] ECODE = 14'(EARLY_CODE);

  state_t        state, nxt;
  logic [15:0]   lfsr;
  logic          fb;
  logic [PW-1:0] presc;
  logic [13:0]   ms_cnt, delay_ms, res_val;
  logic          ms_tick, entry, set_res;
  logic          res_early, res_to, ld_delay;

  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign ms_tick = presc == PS_LAST;
  assign entry   = nxt != state;
  assign set_res = entry && nxt == RESULT;
  assign state_o = state;

  always_comb begin
    nxt       = state;
    ld_delay  = 1'b0;
    res_val   = ms_cnt;
    res_early = 1'b0;
    res_to    = 1'b0;
    if (clear_i) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            nxt      = WAIT;
            ld_delay = 1'b1;
          end
        end
        WAIT: begin
          if (stop_i) begin
            nxt       = RESULT;
            res_early = 1'b1;
            res_val   = ECODE;
          end else if (ms_cnt == delay_ms) begin
            nxt = MEASURE;
          end
        end
        MEASURE: begin
          // stop outranks timeout; the held count equals TMO either way
          if (stop_i) begin
            nxt = RESULT;
          end else if (ms_cnt == TMO) begin
            nxt     = RESULT;
            res_to  = 1'b1;
            res_val = TMO;
          end
        end
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      lfsr     <= 16'hACE1;
      presc    <= '0;
      ms_cnt   <= '0;
      delay_ms <= '0;
    end else begin
      state <= nxt;
      lfsr  <= {lfsr[14:0], fb};
      if (entry || ms_tick) presc <= '0;
      else                  presc <= presc + 1'b1;
      if (entry) begin
        ms_cnt <= '0;
      end else if (ms_tick && ms_cnt != MS_MAX &&
                   (state == WAIT || state == MEASURE)) begin
        ms_cnt <= ms_cnt + 14'd1;
      end
      if (ld_delay)
        delay_ms <= 14'(MIN_DELAY_MS) + (lfsr[13:0] & 14'(DELAY_MASK));
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      led_o          <= 1'b0;
      result_valid_o <= 1'b0;
      reaction_ms_o  <= '0;
      early_o        <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      led_o          <= nxt == MEASURE;
      result_valid_o <= nxt == RESULT;
      if (clear_i) begin
        reaction_ms_o <= '0;
        early_o       <= 1'b0;
        timeout_o     <= 1'b0;
      end else if (set_res) begin
        reaction_ms_o <= res_val;
        early_o       <= res_early;
        timeout_o     <= res_to;
      end
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic [13:0] best;

  // zero means no valid result yet, so the first one always loads
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      best <= '0;
    end else if (set_res && !res_early && !res_to &&
                 (best == '0 || res_val < best)) begin
      best <= res_val;
    end
  end

  assign best_ms_o = best;
`else
  assign best_ms_o = '0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb_reaction_timer_ctrl: randomized rounds checked against a round-level model.
// Best-time expectations follow REACTION_BEST_TIME_EN.
module tb_reaction_timer_ctrl;
  localparam int CPM   = 4;
  localparam int MIND  = 2;
  localparam int MASK  = 3;
  localparam int TMO   = 10;
  localparam int ECODE = 9999;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;
  logic led, valid, early, tmo;
  logic [13:0] rms, best;
  logic [1:0] st;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_lfsr;
  int m_best = 0;

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .CLK_PER_MS(CPM),
    .MIN_DELAY_MS(MIND),
    .DELAY_MASK(MASK),
    .TIMEOUT_MS(TMO),
    .EARLY_CODE(ECODE)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_n),
    .start_i(start),
    .stop_i(stop),
    .clear_i(clear),
    .led_o(led),
    .reaction_ms_o(rms),
    .result_valid_o(valid),
    .early_o(early),
    .timeout_o(tmo),
    .state_o(st),
    .best_ms_o(best)
  );

  // free-running reference LFSR: x^16+x^14+x^13+x^11, stepping every clock
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) start = 1'b1;
    else if (which == 1) stop = 1'b1;
    else clear = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic note_valid(input int r);
`ifdef REACTION_BEST_TIME_EN
    if (m_best == 0 || r < m_best) m_best = r;
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, st, 0);
    check({tag, "_led"}, led, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_early"}, early, 0);
    check({tag, "_tmo"}, tmo, 0);
    check({tag, "_rms"}, rms, 0);
    check({tag, "_best"}, best, m_best);
  endtask

  task automatic check_result(input int r, input int e, input int t);
    check("res_state", st, 3);
    check("res_valid", valid, 1);
    check("res_led", led, 0);
    check("res_rms", rms, r);
    check("res_early", early, e);
    check("res_tmo", tmo, t);
    check("res_best", best, m_best);
  endtask

  // mode: 0 early stop, 1 stop in measure, 2 timeout,
  //       3 clear in wait, 4 clear in measure
  task automatic run_round(input int mode, input int j);
    int d, r;
    d = MIND + int'(m_lfsr & 16'(MASK));
    pulse(0);
    check("wait_state", st, 1);
    if (mode == 0 || mode == 3) begin
      tick(j - 1);
      check("wait_led", led, 0);
      if (mode == 3) begin
        pulse(2);
        check_idle("clr_wait");
        return;
      end
      pulse(1);
      check_result(ECODE, 1, 0);
    end else begin
      tick(CPM * d);
      check("pre_led", led, 0);
      check("pre_state", st, 1);
      tick(1);
      check("meas_led", led, 1);
      check("meas_state", st, 2);
      if (mode == 2) begin
        tick(CPM * TMO);
        check("tmo_pre_state", st, 2);
        tick(1);
        check_result(TMO, 0, 1);
      end else begin
        tick(j - 1);
        if (mode == 4) begin
          pulse(2);
          check_idle("clr_meas");
          return;
        end
        pulse(1);
        r = (j - 1) / CPM;
        note_valid(r);
        check_result(r, 0, 0);
      end
    end
    r = rms;
    repeat (3) begin
      pulse($urandom_range(0, 1));
      check("hold_state", st, 3);
      check("hold_rms", rms, r);
    end
    pulse(2);
    check_idle("clr_res");
  endtask

  initial begin
    int mode, j, d;
    #2;
    check_idle("reset");
    #10 reset_n = 1'b1;
    tick(1);
    pulse(1);
    check("idle_stop", st, 0);

    run_round(1, CPM * 7 + 1);
    run_round(1, CPM * 4 + 1);
    run_round(1, CPM * 6 + 1);
    run_round(0, 1);
`ifdef REACTION_BEST_TIME_EN
    check("best_seq", best, 4);
`else
    check("best_seq", best, 0);
`endif
    run_round(1, CPM * TMO + 1);
    run_round(2, 0);

    for (int k = 0; k < 30; k++) begin
      tick($urandom_range(0, 7));
      mode = $urandom_range(0, 4);
      d = MIND + int'(m_lfsr & 16'(MASK));
      if (mode == 0) j = $urandom_range(1, CPM * d + 1);
      else if (mode == 3) j = $urandom_range(1, CPM * d);
      else if (mode == 1) j = $urandom_range(1, CPM * TMO + 1);
      else j = $urandom_range(1, CPM * TMO);
      run_round(mode, j);
    end

    d = MIND + int'(m_lfsr & 16'(MASK));
    pulse(0);
    tick(CPM * d + 1);
    check("rst_meas_state", st, 2);
    tick(5);
    reset_n = 1'b0;
    m_best = 0;
    #1;
    check_idle("rst_mid");
    tick(1);
    reset_n = 1'b1;
    tick(1);
    run_round(1, 9);
    run_round(0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
